// File: rtl/z80_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80_arb_pkg
// Description : Shared types and defaults for the Z80 memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package z80_arb_pkg;

    localparam int c_MAX_BURST_DEF = 16;
    localparam int c_CPU_MIN_DEF   = 4;
    localparam int c_TIMEOUT_DEF   = 64;
    localparam int c_TMR_W         = 8;

    typedef enum logic [2:0] {
        ST_CPU_OWN  = 3'd0,
        ST_REQ      = 3'd1,
        ST_DMA_OWN  = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_COOLDOWN = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_CPU      = 2'd0,
        SEL_DMA      = 2'd1,
        SEL_DMA_IDLE = 2'd2
    } mux_sel_e;

    // RELEASE parks the bus on the DMA side with the write strobe held off.
    function automatic mux_sel_e sel_for_state(input arb_state_e s);
        case (s)
            ST_DMA_OWN: return SEL_DMA;
            ST_RELEASE: return SEL_DMA_IDLE;
            default:    return SEL_CPU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/z80_busrq_timer.sv
`default_nettype none
// ============================================================================
// Module      : z80_busrq_timer
// Description : Loadable down-counter; done while the count is 1 or 0.
// Revision    : 1.0 - initial release
// ============================================================================
module z80_busrq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // A load of 0 or 1 both give a single-cycle wait.
    assign done_o = (cnt_q <= W'(1));

endmodule
`default_nettype wire

// File: rtl/z80_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : z80_mem_arbiter
// Description : Shares system memory between the tv80s CPU and a DMA requester
//               via BUSRQ/BUSAK. Optional REQ timeout: Z80_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module z80_mem_arbiter
    import z80_arb_pkg::*;
#(
    parameter int MAX_BURST = c_MAX_BURST_DEF,
    parameter int CPU_MIN   = c_CPU_MIN_DEF,
    parameter int TIMEOUT   = c_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_busak_n,
    output logic        cpu_busrq_n,
    input  logic        dma_req,
    input  logic        dma_valid,
    input  logic        dma_we,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_wd,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_wd,
    output logic        mem_we,
    input  logic [7:0]  mem_rd
);

    localparam int                  c_BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(MAX_BURST - 1);
    localparam logic [c_TMR_W-1:0]  c_CPU_MIN_V = c_TMR_W'(CPU_MIN);
    localparam logic [c_TMR_W-1:0]  c_TMO_V     = c_TMR_W'(TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [c_BEAT_W-1:0] beats_q, beats_d;
    logic                busrq_n_q, gnt_q, rvalid_q;
    logic [7:0]          rdata_q;
    logic                w_beat, w_last_beat, w_rd_beat, w_timeout, w_retry_block;
    logic                w_tmr_load, w_tmr_en, w_tmr_done;
    logic [c_TMR_W-1:0]  w_tmr_val;
    mux_sel_e            w_sel;

`ifdef Z80_ARB_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
    logic err_q, relock_q;

    // After a timeout the requester must drop dma_req before it can retry.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q    <= 1'b0;
            relock_q <= 1'b0;
        end else begin
            err_q <= w_timeout;
            if (w_timeout)     relock_q <= 1'b1;
            else if (!dma_req) relock_q <= 1'b0;
        end
    end

    assign dma_err       = err_q;
    assign w_retry_block = relock_q;
`else
    localparam bit c_TMO_EN = 1'b0;
    assign dma_err       = 1'b0;
    assign w_retry_block = 1'b0;
`endif

    assign w_beat      = (state_q == ST_DMA_OWN) && dma_valid;
    assign w_last_beat = w_beat && (beats_q == c_LAST_BEAT);
    assign w_rd_beat   = w_beat && !dma_we;

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = c_CPU_MIN_V;
        w_tmr_en   = 1'b0;
        w_timeout  = 1'b0;
        case (state_q)
            ST_CPU_OWN: begin
                if (dma_req && !w_retry_block) begin
                    state_d    = ST_REQ;
                    w_tmr_load = c_TMO_EN;
                    w_tmr_val  = c_TMO_V;
                end
            end
            ST_REQ: begin
                w_tmr_en = 1'b1;
                if (!dma_req) begin
                    state_d = ST_RELEASE;
                end else if (!cpu_busak_n) begin
                    state_d = ST_DMA_OWN;
                    beats_d = '0;
                end else if (c_TMO_EN && w_tmr_done) begin
                    state_d   = ST_RELEASE;
                    w_timeout = 1'b1;
                end
            end
            ST_DMA_OWN: begin
                if (w_beat) beats_d = beats_q + 1'b1;
                if (!dma_req || w_last_beat) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cpu_busak_n) begin
                    state_d    = ST_COOLDOWN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_CPU_MIN_V;
                end
            end
            ST_COOLDOWN: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) state_d = ST_CPU_OWN;
            end
            default: state_d = ST_CPU_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CPU_OWN;
            beats_q   <= '0;
            busrq_n_q <= 1'b1;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            busrq_n_q <= !((state_d == ST_REQ) || (state_d == ST_DMA_OWN));
            gnt_q     <= (state_d == ST_DMA_OWN);
            rvalid_q  <= w_rd_beat;
            if (w_rd_beat) rdata_q <= mem_rd;
        end
    end

    z80_busrq_timer #(
        .W (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .done_o     (w_tmr_done)
    );

    assign w_sel = sel_for_state(state_q);

    always_comb begin
        mem_a  = cpu_a;
        mem_wd = cpu_do;
        mem_we = !cpu_mreq_n && !cpu_wr_n;
        case (w_sel)
            SEL_DMA: begin
                mem_a  = dma_a;
                mem_wd = dma_wd;
                mem_we = dma_valid && dma_we;
            end
            SEL_DMA_IDLE: begin
                mem_a  = dma_a;
                mem_wd = dma_wd;
                mem_we = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_busrq_n = busrq_n_q;
    assign dma_gnt     = gnt_q;
    assign dma_rvalid  = rvalid_q;
    assign dma_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: doc/z80_mem_arbiter.md
# z80_mem_arbiter

- Shares the single 64 KiB system memory between the tv80s CPU bus and one DMA/loader requester.
- Takes the bus from the CPU with the Z80 BUSRQ/BUSAK handshake, then steers address, write data and write strobe to memory from the owner.
- Bounds DMA bursts so the CPU always gets execution time between them.
- Sits between the CPU pins, the memory model and the bench-side loader.

## Interface
Parameters:
- MAX_BURST, 16, maximum DMA beats per grant (1..255).
- CPU_MIN, 4, cycles the CPU keeps the bus after a release before the next request (0..255).
- TIMEOUT, 64, cycles allowed in REQ for BUSAK (only with macro).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_a  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_mreq_n, cpu_wr_n  in  1  CPU memory strobes.
- cpu_busak_n  in  1  CPU bus acknowledge.
- cpu_busrq_n  out  1  bus request to CPU.
- dma_req  in  1  level; requester wants the bus.
- dma_valid  in  1  one access this cycle (honoured only while dma_gnt).
- dma_we  in  1  1 = write beat, 0 = read beat.
- dma_a  in  16  DMA address.
- dma_wd  in  8  DMA write data.
- dma_gnt  out  1  DMA owns the bus.
- dma_rdata  out  8  registered read data.
- dma_rvalid  out  1  dma_rdata valid.
- dma_err  out  1  one-cycle timeout pulse.
- mem_a  out  16  memory address.
- mem_wd  out  8  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rd  in  8  memory read data.

## Operation
States are CPU_OWN, REQ, DMA_OWN, RELEASE, COOLDOWN.
- CPU_OWN:
  - Memory mux selects the CPU: mem_a=cpu_a, mem_wd=cpu_do, mem_we=!cpu_mreq_n&&!cpu_wr_n.
  - Goes to REQ when dma_req=1.
- REQ:
  - cpu_busrq_n=0.
  - cpu_busak_n sampled 0 goes to DMA_OWN.
  - dma_req dropped goes to RELEASE.
- DMA_OWN:
  - dma_gnt=1 and the mux selects DMA: mem_a=dma_a, mem_wd=dma_wd, mem_we=dma_valid&&dma_we.
  - Each dma_valid cycle is one beat and increments the beat counter (width clog2(MAX_BURST+1)).
  - Goes to RELEASE when dma_req=0, or when the beat counter reaches MAX_BURST on the current beat. That last beat still executes.
- RELEASE:
  - cpu_busrq_n=1, dma_gnt=0, mem_we=0, mux idle on the DMA side.
  - Waits for cpu_busak_n=1, then goes to COOLDOWN.
- COOLDOWN:
  - Mux selects the CPU.
  - Counts CPU_MIN cycles and ignores dma_req; goes to CPU_OWN when done.
  - CPU_MIN=0 means one pass-through cycle.

Read beats:
- dma_rdata<=mem_rd, dma_rvalid=1 on the cycle after a DMA_OWN beat with dma_valid&&!dma_we.
- Otherwise dma_rvalid=0.

Simultaneous events:
- dma_req drops on the same cycle as the last beat: the beat executes, then RELEASE.
- dma_valid while not granted: ignored, no memory effect.

Reset:
- Forces CPU_OWN from any state, including mid-burst.
- Output values: cpu_busrq_n=1, dma_gnt=0, dma_rvalid=0, dma_err=0, dma_rdata=8'h00.
- Beat and cooldown counters clear to 0.

## Timing
- dma_req rising in CPU_OWN: cpu_busrq_n low at the next edge.
- cpu_busak_n low sampled: dma_gnt high one edge later.
- Request-to-grant latency is 2 cycles plus CPU BUSAK latency.
- All state outputs are registered. The memory mux is combinational from the registered state only.
- A burst of N beats with dma_valid held high occupies exactly N cycles of DMA_OWN.

## Configuration
Macro: Z80_ARB_TIMEOUT_EN.
- Defined:
  - A REQ-state counter runs.
  - If BUSAK has not arrived after TIMEOUT cycles: pulse dma_err one cycle, go to RELEASE, then COOLDOWN.
  - The requester must drop and re-raise dma_req to retry.
- Undefined:
  - REQ waits indefinitely.
  - dma_err is tied 0 and the counter is absent.

## Structure
- Package z80_arb_pkg holds:
  - the state enum;
  - default MAX_BURST/CPU_MIN/TIMEOUT localparams;
  - the mux-select encoding.
- Sub-module z80_busrq_timer: the loadable down-counter.
  - Used for cooldown.
  - Also used for timeout, only when Z80_ARB_TIMEOUT_EN is defined.

## Test plan
- Reset mid-burst (beat 5, MAX_BURST=16): next cycle cpu_busrq_n=1, dma_gnt=0, dma_rvalid=0; CPU program at 0000 (dd cb b7 01, IX=28fd) then sets 28b4 from e3 to c7.
- DMA write burst of 4 to 4000..4003 (11,22,33,44): busrq_n low 1 cycle after dma_req, 4 grant cycles, memory holds those bytes; CPU resumes with correct PC.
- DMA read of 28b4=e3: dma_rvalid high one cycle after the beat, dma_rdata=e3.
- dma_req held with 20 beats, MAX_BURST=16: grant drops after beat 16, CPU_MIN=4 cooldown cycles, re-grant completes the remaining 4 beats.
- With Z80_ARB_TIMEOUT_EN, busak_n forced high: dma_err pulses exactly at REQ cycle 64, busrq_n returns high.
- dma_valid while ungranted with dma_we=1 to 5000: mem[5000] unchanged.
